// File: rtl/patch_step_sequencer.sv
// Step sequencer for the tiled drum-mesh solver: holds the patch array in init,
// strobes time steps, captures the middle node and updates the nonlinear tension rho.
module patch_step_sequencer #(
    parameter int          INIT_CYCLES   = 4,
    parameter int          SETTLE_CYCLES = 3,
    parameter int          RHO_SHIFT     = 4,
    parameter logic [17:0] RHO_MAX       = 18'h0FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] num_steps,
    input  logic [17:0] rho_base,
    input  logic [17:0] mid_node_in,
    input  logic        sample_ready,
    output logic        array_reset,
    output logic        array_enable,
    output logic [17:0] rho_out,
    output logic [17:0] sample_out,
    output logic        sample_valid,
    output logic [15:0] step_count,
    output logic        busy,
    output logic        done
);

    // state    | meaning
    // IDLE     | array held in reset, waiting for start
    // INIT     | array reset held for INIT_CYCLES
    // STEP     | one-cycle array_enable strobe
    // SETTLE   | wait SETTLE_CYCLES for the mesh to settle
    // CAPTURE  | sample middle node, update rho
    // WAIT_ACK | hold sample until downstream accepts
    // DONE     | one-cycle done pulse, array back in reset
    typedef enum logic [2:0] {
        IDLE, INIT, STEP, SETTLE, CAPTURE, WAIT_ACK, DONE
    } state_t;

    localparam logic [7:0] INIT_LOAD   = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  timer;
    logic [15:0] num_q;
    logic [17:0] base_q;
    logic        stop_pending;
    logic        stop_eff;
    logic [15:0] count_inc;
    logic        reset_d, enable_d, busy_d, done_d;

    logic signed [17:0] mid_s;
    logic signed [35:0] prod;
    logic        [18:0] sq;
    logic        [18:0] sq_shift;
    logic signed [19:0] sum;
    logic        [17:0] rho_nx;
    logic               unused_bits;

    assign stop_eff  = stop_pending | stop;
    assign count_inc = step_count + 16'd1;

    // Square is non-negative, so bits [35:17] are the unsigned 19-bit result.
    assign mid_s       = mid_node_in;
    assign prod        = mid_s * mid_s;
    assign sq          = prod[35:17];
    assign sq_shift    = sq >> RHO_SHIFT;
    assign sum         = {{2{base_q[17]}}, base_q} + {1'b0, sq_shift};
    assign rho_nx      = (sum > $signed({2'b00, RHO_MAX})) ? RHO_MAX : sum[17:0];
    assign unused_bits = ^{prod[16:0], sum[19:18]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = INIT;
            INIT:     if (timer == 8'd0) state_nx = stop_eff ? DONE : STEP;
            STEP:     state_nx = SETTLE;
            SETTLE:   if (timer == 8'd0) state_nx = CAPTURE;
            CAPTURE:  state_nx = WAIT_ACK;
            WAIT_ACK: if (sample_ready)
                          state_nx = (((num_q != 16'd0) && (count_inc == num_q)) || stop_eff)
                                     ? DONE : STEP;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they register in step with it.
    always_comb begin
        reset_d  = (state_nx == IDLE) || (state_nx == INIT) || (state_nx == DONE);
        enable_d = (state_nx == STEP);
        busy_d   = (state_nx != IDLE);
        done_d   = (state_nx == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            array_reset  <= 1'b1;
            array_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rho_out      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            step_count   <= '0;
            timer        <= '0;
            num_q        <= '0;
            base_q       <= '0;
            stop_pending <= 1'b0;
        end else begin
            array_reset  <= reset_d;
            array_enable <= enable_d;
            busy         <= busy_d;
            done         <= done_d;

            if (((state == INIT) || (state == SETTLE)) && (timer != 8'd0))
                timer <= timer - 8'd1;
            if ((state != IDLE) && stop)
                stop_pending <= 1'b1;

            case (state)
                IDLE: if (start) begin
                    num_q        <= num_steps;
                    base_q       <= rho_base;
                    rho_out      <= rho_base;
                    step_count   <= '0;
                    stop_pending <= stop;
                    timer        <= INIT_LOAD;
                end
                STEP: timer <= SETTLE_LOAD;
                CAPTURE: begin
                    sample_out   <= mid_node_in;
                    sample_valid <= 1'b1;
                    rho_out      <= rho_nx;
                end
                WAIT_ACK: if (sample_ready) begin
                    sample_valid <= 1'b0;
                    step_count   <= count_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/patch_step_sequencer.md
# patch_step_sequencer

Sequences the tiled drum-mesh solver: holds the patch array at its initial condition, then issues one-cycle time-step enables and waits a fixed settle interval after each. It samples the middle-node output, updates the nonlinear tension term rho from that amplitude, and streams each sample downstream over a valid/ready handshake. It sits between the host/audio side and the patch array; it drives the array's reset, enable and rho inputs.

## Interface
- INIT_CYCLES, 4: cycles the array reset is held after start
- SETTLE_CYCLES, 3: wait cycles after each enable pulse before sampling
- RHO_SHIFT, 4: right shift applied to mid-node² before adding to rho_base
- RHO_MAX, 18'h0FFFF: saturation ceiling for rho_out
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a run; honoured in IDLE only
- stop  in  1  request early termination
- num_steps  in  16  steps per run; 0 = run until stop
- rho_base  in  18  signed 1.17 base tension, sampled at start
- mid_node_in  in  18  signed 1.17 middle node from the patch array
- sample_ready  in  1  downstream accepts sample
- array_reset  out  1  reset/init to patch array
- array_enable  out  1  one-cycle step strobe to patch array
- rho_out  out  18  signed 1.17 rho to patch array
- sample_out  out  18  captured mid-node value
- sample_valid  out  1  sample_out valid
- step_count  out  16  completed (handshaken) steps in the current run
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, INIT, STEP, SETTLE, CAPTURE, WAIT_ACK, DONE.
- IDLE: array_reset=1. On start: latch num_steps and rho_base, load rho_out←rho_base, clear step_count and stop_pending. Then go to INIT.
- INIT: array_reset=1 for INIT_CYCLES cycles. Then go to DONE if stop_pending, else to STEP.
- STEP: array_reset=0, array_enable=1 for exactly one cycle. Then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles. Then go to CAPTURE.
- CAPTURE (1 cycle): sample_out←mid_node_in, set sample_valid, and update rho_out:
  - sq = (mid×mid)>>17, 36-bit signed product, result unsigned 19 bits
  - sum = rho_base + (sq>>RHO_SHIFT), 19 bits
  - rho_out = min(sum, RHO_MAX)
  - Then go to WAIT_ACK.
- WAIT_ACK: hold sample_out and sample_valid until sample_ready is high.
  - On the handshake cycle: clear sample_valid and increment step_count.
  - Then go to DONE if (num_steps≠0 and the new count equals num_steps) or stop_pending; else go to STEP.
- DONE: array_reset=1, done=1 for one cycle, then go to IDLE. rho_out holds its value.
- stop: seen high in any non-IDLE state, it sets stop_pending. The run ends at the next INIT exit or handshake, so a step in flight always completes and delivers its sample.
- start while busy: ignored. start and stop in the same IDLE cycle: the run starts with stop_pending already set and ends after INIT with no steps.
- step_count wraps 0xFFFF→0 only when num_steps=0.

## Timing
- Reset values: array_reset=1, array_enable=0, rho_out=0, sample_out=0, sample_valid=0, step_count=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-run aborts immediately to these values. Any pending sample is lost.
- All outputs are registered.
- If start is sampled at edge k, busy goes high after edge k. The first array_enable is high in cycle k+1+INIT_CYCLES.
- With sample_ready tied high, steps repeat every 3+SETTLE_CYCLES cycles: STEP 1, SETTLE SETTLE_CYCLES, CAPTURE 1, WAIT_ACK 1.
- sample_valid rises the cycle after CAPTURE. rho_out updates on the same edge as sample_out.
- done pulses the cycle after the final handshake. busy falls the cycle after done.

## Test plan
- Reset, then start, with num_steps=3, ready=1 and defaults → array_reset high 4 cycles, then array_enable pulses every 6 cycles. Expect exactly 3 pulses and 3 samples, step_count=3, and one done pulse.
- rho_base=0x00800 with mid_node_in=0x10000 → rho_out=0x01000 after the first CAPTURE. With mid_node_in=0x30000 (−0.5), rho_out is also 0x01000.
- Saturation: rho_base=0x0FF00 with mid=0x10000 → rho_out=0x0FFFF.
- Backpressure: hold sample_ready=0 for 10 cycles → sample_valid and sample_out stay stable, and there is no array_enable until the handshake. step_count increments only on the handshake.
- num_steps=0: stop asserted during SETTLE of step 5 → step 5's sample is delivered, step_count=5, then done. No sixth array_enable.
- Reset asserted in WAIT_ACK → all outputs return to reset values on the same edge. A following start runs normally from step_count=0.
